snake_engine: RTL and testbench



---
 rtl/snake_pkg.sv | 23 ++
 rtl/snake_tick_gen.sv | 29 ++
 rtl/snake_engine.sv | 193 +++++++++++++++++++
 tb/tb_snake_engine.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types for the snake game core: direction and game-state encodings
// plus the reversal helper used by the direction filter.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DEAD = 2'b10
    } state_t;

    // Opposite pairs differ only in the low bit of the encoding.
    function automatic dir_t opposite(input dir_t d);
        return dir_t'(d ^ 2'b01);
    endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Movement tick generator: counts 0..TICK_DIV-1 while enabled and emits a
// one-cycle tick on the terminal count.
module snake_tick_gen #(
    parameter int TICK_DIV = 20000000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    assign tick = enable && !clear && (r_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (clear)
            r_cnt <= '0;
        else if (enable)
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end

endmodule

// File: rtl/snake_engine.sv
// Snake game core: segment shift register, direction filter, collision and
// food detection, IDLE/RUN/DEAD control and per-pixel snake/head flags.
module snake_engine
    import snake_pkg::*;
#(
    parameter int MAX_LEN  = 16,
    parameter int CELL     = 10,
    parameter int GRID_W   = 64,
    parameter int GRID_H   = 48,
    parameter int TICK_DIV = 20000000,
    parameter int WRAP     = 1,
    parameter int START_X  = 40,
    parameter int START_Y  = 40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic [5:0] food_x,
    input  logic [5:0] food_y,
    input  logic       food_valid,
    input  logic [9:0] x_pos,
    input  logic [8:0] y_pos,
    output logic       eat,
    output logic       game_over,
    output logic       running,
    output logic [6:0] length,
    output logic [7:0] score,
    output logic       snake_pix,
    output logic       head_pix
);

    state_t     r_state, w_state_nxt;
    dir_t       r_dir, r_cdir, w_req, w_base;
    logic [5:0] r_seg_x [MAX_LEN];
    logic [5:0] r_seg_y [MAX_LEN];
    logic [6:0] r_len;
    logic [7:0] r_score;
    logic       r_eat;

    logic       w_tick, w_start, w_req_vld, w_accept;
    logic [5:0] w_nx, w_ny;
    logic       w_wall, w_self, w_grow, w_hit, w_move;

    function automatic logic pix_in(input logic [5:0] cx, input logic [5:0] cy,
                                    input logic [9:0] px, input logic [8:0] py);
        int x0, y0;
        x0 = int'(cx) * CELL;
        y0 = int'(cy) * CELL;
        return (int'(px) >= x0) && (int'(px) < x0 + CELL) &&
               (int'(py) >= y0) && (int'(py) < y0 + CELL);
    endfunction

    snake_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .enable (r_state == ST_RUN && !pause),
        .clear  (r_state != ST_RUN),
        .tick   (w_tick)
    );

    assign w_start = start && (r_state != ST_RUN);

    always_comb begin
        w_req_vld = 1'b1;
        w_req     = DIR_UP;
        if (btn_right)     w_req = DIR_RIGHT;
        else if (btn_left) w_req = DIR_LEFT;
        else if (btn_up)   w_req = DIR_UP;
        else if (btn_down) w_req = DIR_DOWN;
        else               w_req_vld = 1'b0;
    end

    // On a tick the move in r_dir becomes the committed one this very cycle.
    assign w_base   = w_tick ? r_dir : r_cdir;
    assign w_accept = w_req_vld && (w_req != opposite(w_base));

    always_comb begin
        w_nx   = r_seg_x[0];
        w_ny   = r_seg_y[0];
        w_wall = 1'b0;
        case (r_dir)
            DIR_UP:
                if (r_seg_y[0] == 6'd0) begin
                    w_ny = 6'(GRID_H - 1); w_wall = (WRAP == 0);
                end else w_ny = r_seg_y[0] - 6'd1;
            DIR_DOWN:
                if (r_seg_y[0] == 6'(GRID_H - 1)) begin
                    w_ny = 6'd0; w_wall = (WRAP == 0);
                end else w_ny = r_seg_y[0] + 6'd1;
            DIR_LEFT:
                if (r_seg_x[0] == 6'd0) begin
                    w_nx = 6'(GRID_W - 1); w_wall = (WRAP == 0);
                end else w_nx = r_seg_x[0] - 6'd1;
            default:
                if (r_seg_x[0] == 6'(GRID_W - 1)) begin
                    w_nx = 6'd0; w_wall = (WRAP == 0);
                end else w_nx = r_seg_x[0] + 6'd1;
        endcase
    end

    assign w_grow = food_valid && (w_nx == food_x) && (w_ny == food_y);

    // The tail cell is only safe when it actually vacates, i.e. no growth.
    always_comb begin
        w_self = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((i < int'(r_len) - 1 || (i == int'(r_len) - 1 && w_grow)) &&
                r_seg_x[i] == w_nx && r_seg_y[i] == w_ny)
                w_self = 1'b1;
        end
    end

    assign w_hit  = w_wall || w_self;
    assign w_move = w_tick && !w_hit;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DEAD: if (start) w_state_nxt = ST_RUN;
            ST_RUN:           if (w_tick && w_hit) w_state_nxt = ST_DEAD;
            default:          w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dir   <= DIR_UP;
            r_cdir  <= DIR_UP;
            r_len   <= 7'd3;
            r_score <= '0;
            r_eat   <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                r_seg_x[i] <= 6'(START_X);
                r_seg_y[i] <= 6'(START_Y + i);
            end
        end else begin
            r_eat <= w_move && w_grow;
            if (w_tick)   r_cdir <= r_dir;
            if (w_accept) r_dir  <= w_req;
            if (w_move) begin
                r_seg_x[0] <= w_nx;
                r_seg_y[0] <= w_ny;
                for (int i = 1; i < MAX_LEN; i++) begin
                    r_seg_x[i] <= r_seg_x[i-1];
                    r_seg_y[i] <= r_seg_y[i-1];
                end
                if (w_grow) begin
                    if (r_len < 7'(MAX_LEN)) r_len   <= r_len + 7'd1;
                    if (r_score != 8'hFF)    r_score <= r_score + 8'd1;
                end
            end
            // A new game restores the power-on snake, overriding any button.
            if (w_start) begin
                r_dir   <= DIR_UP;
                r_cdir  <= DIR_UP;
                r_len   <= 7'd3;
                r_score <= '0;
                for (int i = 0; i < MAX_LEN; i++) begin
                    r_seg_x[i] <= 6'(START_X);
                    r_seg_y[i] <= 6'(START_Y + i);
                end
            end
        end
    end

    always_comb begin
        snake_pix = 1'b0;
        head_pix  = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < int'(r_len) && pix_in(r_seg_x[i], r_seg_y[i], x_pos, y_pos)) begin
                snake_pix = 1'b1;
                if (i == 0) head_pix = 1'b1;
            end
        end
    end

    assign eat       = r_eat;
    assign game_over = (r_state == ST_DEAD);
    assign running   = (r_state == ST_RUN);
    assign length    = r_len;
    assign score     = r_score;

endmodule

// File: tb/tb_snake_engine.sv
// Bench for snake_engine: two instances (walled MAX_LEN=4, wrapping MAX_LEN=8)
// share random stimulus and are compared every cycle with a cell-level model.
module tb_snake_engine;

    localparam int TD = 4;
    localparam int P_MAX  [2] = '{4, 8};
    localparam int P_WRAP [2] = '{0, 1};
    localparam int DX  [4] = '{0, 0, -1, 1};
    localparam int DY  [4] = '{-1, 1, 0, 0};
    localparam int OPP [4] = '{1, 0, 3, 2};

    logic       clk = 1'b0;
    logic       rst, start_i, pause_i, up_i, down_i, left_i, right_i, fv_i;
    logic [5:0] fx_i, fy_i;
    logic [9:0] x_pos_i;
    logic [8:0] y_pos_i;
    logic [1:0] eat_o, go_o, run_o, spix_o, hpix_o;
    logic [6:0] len_o [2];
    logic [7:0] score_o [2];

    int n_chk = 0;
    int n_err = 0;

    int m_x [2][64];
    int m_y [2][64];
    int m_len [2], m_st [2], m_dir [2], m_cdir [2], m_score [2], m_cnt [2], m_eat [2];

    always #5 clk = ~clk;

    snake_engine #(.MAX_LEN(4), .TICK_DIV(TD), .WRAP(0)) u_a (
        .clk(clk), .rst(rst), .start(start_i), .pause(pause_i),
        .btn_up(up_i), .btn_down(down_i), .btn_left(left_i), .btn_right(right_i),
        .food_x(fx_i), .food_y(fy_i), .food_valid(fv_i), .x_pos(x_pos_i), .y_pos(y_pos_i),
        .eat(eat_o[0]), .game_over(go_o[0]), .running(run_o[0]), .length(len_o[0]),
        .score(score_o[0]), .snake_pix(spix_o[0]), .head_pix(hpix_o[0]));

    snake_engine #(.MAX_LEN(8), .TICK_DIV(TD), .WRAP(1)) u_b (
        .clk(clk), .rst(rst), .start(start_i), .pause(pause_i),
        .btn_up(up_i), .btn_down(down_i), .btn_left(left_i), .btn_right(right_i),
        .food_x(fx_i), .food_y(fy_i), .food_valid(fv_i), .x_pos(x_pos_i), .y_pos(y_pos_i),
        .eat(eat_o[1]), .game_over(go_o[1]), .running(run_o[1]), .length(len_o[1]),
        .score(score_o[1]), .snake_pix(spix_o[1]), .head_pix(hpix_o[1]));

    task automatic chk_eq(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_new_game(input int k);
        m_len[k] = 3; m_score[k] = 0; m_dir[k] = 0; m_cdir[k] = 0;
        for (int i = 0; i < 64; i++) begin
            m_x[k][i] = 40;
            m_y[k][i] = (40 + i) % 64;
        end
    endtask

    task automatic model_reset(input int k);
        m_st[k] = 0; m_cnt[k] = 0; m_eat[k] = 0;
        model_new_game(k);
    endtask

    // One clock edge of the game rules, evaluated on the inputs now applied.
    task automatic model_step(input int k);
        bit tick, wall, grow, hit;
        int nx, ny, req, base;
        tick = (m_st[k] == 1) && !pause_i && (m_cnt[k] == TD - 1);
        m_eat[k] = 0;
        if (m_st[k] != 1) m_cnt[k] = 0;
        else if (!pause_i) m_cnt[k] = (m_cnt[k] + 1) % TD;
        base = tick ? m_dir[k] : m_cdir[k];
        if (tick) begin
            nx = m_x[k][0] + DX[m_dir[k]];
            ny = m_y[k][0] + DY[m_dir[k]];
            wall = 0;
            if (nx < 0 || nx >= 64 || ny < 0 || ny >= 48) begin
                if (P_WRAP[k] != 0) begin nx = (nx + 64) % 64; ny = (ny + 48) % 48; end
                else wall = 1;
            end
            grow = fv_i && (nx == int'(fx_i)) && (ny == int'(fy_i));
            hit = wall;
            for (int i = 1; i < m_len[k]; i++)
                if (m_x[k][i] == nx && m_y[k][i] == ny && (grow || i != m_len[k] - 1)) hit = 1;
            if (hit) m_st[k] = 2;
            else begin
                for (int i = 63; i > 0; i--) begin
                    m_x[k][i] = m_x[k][i-1];
                    m_y[k][i] = m_y[k][i-1];
                end
                m_x[k][0] = nx; m_y[k][0] = ny;
                if (grow) begin
                    m_eat[k] = 1;
                    if (m_len[k] < P_MAX[k]) m_len[k]++;
                    if (m_score[k] < 255) m_score[k]++;
                end
            end
            m_cdir[k] = m_dir[k];
        end
        req = right_i ? 3 : left_i ? 2 : up_i ? 0 : down_i ? 1 : -1;
        if (req >= 0 && req != OPP[base]) m_dir[k] = req;
        if (start_i && m_st[k] != 1) begin
            m_st[k] = 1;
            model_new_game(k);
        end
    endtask

    task automatic compare_all();
        int cx, cy, es, eh;
        cx = int'(x_pos_i) / 10;
        cy = int'(y_pos_i) / 10;
        for (int k = 0; k < 2; k++) begin
            es = 0; eh = 0;
            for (int i = 0; i < m_len[k]; i++)
                if (m_x[k][i] == cx && m_y[k][i] == cy) begin
                    es = 1;
                    if (i == 0) eh = 1;
                end
            chk_eq($sformatf("eat%0d", k),   eat_o[k],        m_eat[k]);
            chk_eq($sformatf("over%0d", k),  go_o[k],         (m_st[k] == 2) ? 1 : 0);
            chk_eq($sformatf("run%0d", k),   run_o[k],        (m_st[k] == 1) ? 1 : 0);
            chk_eq($sformatf("len%0d", k),   len_o[k],        m_len[k]);
            chk_eq($sformatf("score%0d", k), score_o[k],      m_score[k]);
            chk_eq($sformatf("spix%0d", k),  spix_o[k],       es);
            chk_eq($sformatf("hpix%0d", k),  hpix_o[k],       eh);
        end
    endtask

    task automatic cycle();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        compare_all();
        start_i = 0; up_i = 0; down_i = 0; left_i = 0; right_i = 0;
    endtask

    task automatic randomize_inputs();
        int sel, k, i;
        start_i = ($urandom % 64) == 0;
        pause_i = ($urandom % 8) == 0;
        up_i    = ($urandom % 40) == 0;
        down_i  = ($urandom % 40) == 0;
        left_i  = ($urandom % 40) == 0;
        right_i = ($urandom % 40) == 0;
        fv_i    = ($urandom % 4) != 0;
        sel = $urandom % 4;
        if (sel < 2) begin
            fx_i = 6'((m_x[sel][0] + DX[m_dir[sel]] + 64) % 64);
            fy_i = 6'((m_y[sel][0] + DY[m_dir[sel]] + 48) % 48);
        end else begin
            fx_i = 6'($urandom % 64);
            fy_i = 6'($urandom % 48);
        end
        sel = $urandom % 4;
        if (sel < 3) begin
            k = (sel == 0) ? 0 : 1;
            i = $urandom % m_len[k];
            x_pos_i = 10'(m_x[k][i] * 10 + $urandom % 10);
            y_pos_i = 9'(m_y[k][i] * 10 + $urandom % 10);
        end else begin
            x_pos_i = 10'($urandom % 640);
            y_pos_i = 9'($urandom % 480);
        end
    endtask

    initial begin
        rst = 1; start_i = 0; pause_i = 0; up_i = 0; down_i = 0; left_i = 0; right_i = 0;
        fv_i = 0; fx_i = 0; fy_i = 0; x_pos_i = 10'd400; y_pos_i = 9'd400;
        model_reset(0); model_reset(1);
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        chk_eq("rst.len", len_o[1], 3);
        chk_eq("rst.head", hpix_o[1], 1);
        @(negedge clk);
        rst = 0;

        // Start and let the snake climb three cells.
        start_i = 1;
        cycle();
        x_pos_i = 10'd400; y_pos_i = 9'd390;
        repeat (12) cycle();
        chk_eq("up3.pix390", spix_o[1], 1);
        y_pos_i = 9'd420;
        #1;
        chk_eq("up3.pix420", spix_o[1], 0);
        y_pos_i = 9'd370;
        #1;
        chk_eq("up3.head370", hpix_o[1], 1);

        // Straight up long enough for the walled instance to die and the other to wrap.
        repeat (60 * TD) cycle();
        chk_eq("wall.over", go_o[0], 1);
        chk_eq("wrap.run", run_o[1], 1);

        // Asynchronous reset between clock edges.
        #2;
        rst = 1;
        #1;
        model_reset(0); model_reset(1);
        x_pos_i = 10'd400; y_pos_i = 9'd400;
        #1;
        compare_all();
        chk_eq("arst.len", len_o[1], 3);
        chk_eq("arst.score", score_o[1], 0);
        @(negedge clk);
        rst = 0;
        start_i = 1;
        cycle();
        chk_eq("arst.start", run_o[0], 1);

        for (int n = 0; n < 16000; n++) begin
            randomize_inputs();
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
